// File: rtl/slug_pkg.sv
// slug_pkg: definitions shared by the slug CPU microcode sequencer.
//   state_e        sequencer states (HALT, FETCH, EXEC)
//   *_BIT          bit positions inside the 24-bit control word
//   *_WORD_DEF     idle/fetch control words and the stall hold mask
package slug_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    // Control word bit positions (control2 = [23:16], control1 = [15:8], control0 = [7:0])
    localparam int END_BIT   = 15;  // former unused control1[7], active-high
    localparam int RERAM_BIT = 14;  // active-low RAM read
    localparam int WERAM_BIT = 13;  // active-low RAM write
    localparam int LDBC_BIT  = 21;
    localparam int LDOUT_BIT = 19;
    localparam int LDALU_BIT = 12;
    localparam int LDFL_BIT  = 10;
    localparam int LDA_BIT   = 9;
    localparam int LDPC_BIT  = 1;
    localparam int INCPC_BIT = 0;

    localparam logic [23:0] NOP_WORD_DEF   = 24'hFFFFFE;
    localparam logic [23:0] FETCH_WORD_DEF = 24'hFFFFFF;
    localparam logic [23:0] HOLD_MASK_DEF  = 24'h281603;

endpackage

// File: rtl/useq.sv
// useq: microcode sequencer for the slug 4-bit CPU.
// Runs fetch/execute: FETCH latches the program byte into ir, EXEC walks
// microinstructions at ROM address {ir, step} until the end bit or the last
// step, stalling on RAM microsteps while mem_rdy is low.
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   synchronous active-high reset
//   run        in   run enable, sampled at instruction boundaries
//   prog       in   program byte at the current PC
//   ucode      in   microcode ROM data for address ua
//   mem_rdy    in   RAM ready; low extends a RAM microstep
//   ua         out  microcode address {ir, step}
//   ctl        out  control word to the datapath
//   ir         out  instruction register
//   step       out  current micro-step
//   fetch      out  high in FETCH
//   busy       out  high when not in HALT
//   ucode_err  out  sticky step-budget overrun flag
//
// state    | meaning
// ST_HALT  | idle, ctl = NOP_WORD, waits for run
// ST_FETCH | one cycle, ctl = FETCH_WORD, ir <= prog
// ST_EXEC  | microinstructions from ucode, stalls on RAM steps
module useq
    import slug_pkg::*;
#(
    parameter int                STEP_W     = 3,
    parameter int                CTL_W      = 24,
    parameter logic [CTL_W-1:0]  NOP_WORD   = NOP_WORD_DEF,
    parameter logic [CTL_W-1:0]  FETCH_WORD = FETCH_WORD_DEF,
    parameter logic [CTL_W-1:0]  HOLD_MASK  = HOLD_MASK_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [7:0]            prog,
    input  logic [CTL_W-1:0]      ucode,
    input  logic                  mem_rdy,
    output logic [8+STEP_W-1:0]   ua,
    output logic [CTL_W-1:0]      ctl,
    output logic [7:0]            ir,
    output logic [STEP_W-1:0]     step,
    output logic                  fetch,
    output logic                  busy,
    output logic                  ucode_err
);

    localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

    state_e            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              err_q, err_d;

    logic end_bit, mem_op, stall, last_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
            ir_q    <= 8'h00;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        step_d    = step_q;
        err_d     = err_q;
        ctl       = NOP_WORD;
        end_bit   = ucode[END_BIT];
        mem_op    = ~ucode[RERAM_BIT] | ~ucode[WERAM_BIT];
        stall     = 1'b0;
        last_step = 1'b0;

        unique case (state_q)
            ST_HALT: begin
                step_d = '0;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctl     = FETCH_WORD;
                ir_d    = prog;
                step_d  = '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                stall = mem_op & ~mem_rdy;
                if (stall) begin
                    // RAM strobes stay asserted; only the register loads and
                    // PC updates are suppressed so the step can repeat cleanly.
                    ctl = (ucode & ~HOLD_MASK) | (NOP_WORD & HOLD_MASK);
                end else begin
                    ctl       = ucode;
                    last_step = end_bit | (step_q == STEP_MAX);
                    if (last_step) begin
                        step_d  = '0;
                        state_d = run ? ST_FETCH : ST_HALT;
                        if (!end_bit) err_d = 1'b1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
                step_d  = '0;
            end
        endcase
    end

    assign ua        = {ir_q, step_q};
    assign ir        = ir_q;
    assign step      = step_q;
    assign fetch     = (state_q == ST_FETCH);
    assign busy      = (state_q != ST_HALT);
    assign ucode_err = err_q;

endmodule

// File: tb/tb_useq.sv
module tb_useq;

    localparam logic [23:0] NOP   = 24'hFFFFFE;
    localparam logic [23:0] FWORD = 24'hFFFFFF;
    localparam logic [23:0] HOLD  = 24'h281603;

    logic        clk = 1'b0;
    logic        rst, run, mem_rdy;
    logic [7:0]  prog;
    logic [23:0] ucode;
    logic [10:0] ua;
    logic [23:0] ctl;
    logic [7:0]  ir;
    logic [2:0]  step;
    logic        fetch, busy, ucode_err;

    logic [23:0] rom [0:2047];
    int          stall_n [8];
    int          tests = 0;
    int          fails = 0;
    logic        err_exp = 1'b0;

    always #5 clk = ~clk;

    assign ucode = rom[ua];

    useq dut (
        .clk(clk), .rst(rst), .run(run), .prog(prog), .ucode(ucode),
        .mem_rdy(mem_rdy), .ua(ua), .ctl(ctl), .ir(ir), .step(step),
        .fetch(fetch), .busy(busy), .ucode_err(ucode_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Instruction length from the ROM contents: steps up to and including
    // the first end bit, or all 8 steps if none is set.
    function automatic int instr_len(input logic [7:0] op, output logic overrun);
        logic [10:0] a;
        overrun = 1'b1;
        for (int s = 0; s < 8; s++) begin
            a = {op, 3'(s)};
            if (rom[a][15]) begin
                overrun = 1'b0;
                return s + 1;
            end
        end
        return 8;
    endfunction

    // Entered in the FETCH cycle; leaves in the cycle after the last step.
    task automatic run_instr(input logic [7:0] op, input logic next_run);
        int          len;
        logic        ovr;
        logic [23:0] w;
        logic [10:0] a;
        logic        memop;
        len = instr_len(op, ovr);
        chk("fetch_flag", 32'(fetch), 32'd1);
        chk("fetch_ctl", 32'(ctl), 32'(FWORD));
        prog = op;
        next_cycle();
        prog = 8'($urandom);
        run  = next_run;
        chk("ir", 32'(ir), 32'(op));
        for (int s = 0; s < len; s++) begin
            a = {op, 3'(s)};
            w = rom[a];
            memop = ~w[14] | ~w[13];
            if (memop) begin
                for (int k = 0; k < stall_n[s]; k++) begin
                    mem_rdy = 1'b0;
                    #1;
                    chk("stall_ua", 32'(ua), 32'(a));
                    chk("stall_ctl", 32'(ctl), 32'((w & ~HOLD) | (NOP & HOLD)));
                    next_cycle();
                end
                mem_rdy = 1'b1;
            end else begin
                mem_rdy = 1'($urandom);
            end
            #1;
            chk("exec_ua", 32'(ua), 32'(a));
            chk("exec_ctl", 32'(ctl), 32'(w));
            next_cycle();
        end
        mem_rdy = 1'b1;
        if (ovr) err_exp = 1'b1;
        chk("ucode_err", 32'(ucode_err), 32'(err_exp));
        if (next_run) begin
            chk("refetch", 32'(fetch), 32'd1);
        end else begin
            chk("halt_busy", 32'(busy), 32'd0);
            chk("halt_ctl", 32'(ctl), 32'(NOP));
        end
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 8; i++) stall_n[i] = 0;
    endtask

    logic [7:0] op;
    logic       nr;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 24'hFFFFFE & ~24'h008000;
        clear_stalls();
        rst = 1'b1; run = 1'b1; mem_rdy = 1'b1; prog = 8'h00;
        next_cycle();
        next_cycle();
        chk("rst_ctl", 32'(ctl), 32'(NOP));
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fetch", 32'(fetch), 32'd0);
        chk("rst_ua", 32'(ua), 32'd0);
        chk("rst_err", 32'(ucode_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_halt", 32'(busy), 32'd0);
        next_cycle();

        // Two-step opcode 3A
        rom[11'h1D0] = 24'hFF7FFE;
        rom[11'h1D1] = 24'hFFFFFE;
        run_instr(8'h3A, 1'b1);

        // Step 0 reads RAM with two wait cycles
        rom[11'h1D0] = 24'h123456 & ~24'h00C000 | 24'h002000;
        stall_n[0] = 2;
        run_instr(8'h3A, 1'b1);
        clear_stalls();

        // No end bit anywhere: full 8-step overrun
        for (int s = 0; s < 8; s++) rom[11'h1D0 + 11'(s)] = 24'hFF7FFE;
        run_instr(8'h3A, 1'b1);
        rom[11'h1D0] = 24'hFF7FFE;
        rom[11'h1D1] = 24'hFFFFFE;
        run_instr(8'h3A, 1'b1);

        // run dropped during step 0: completes, then HALT
        run_instr(8'h3A, 1'b0);
        next_cycle();
        chk("halt_hold", 32'(busy), 32'd0);
        run = 1'b1;
        next_cycle();
        chk("restart_fetch", 32'(fetch), 32'd1);

        // Randomized instructions
        for (int i = 0; i < 2048; i++) rom[i] = 24'($urandom);
        for (int t = 0; t < 40; t++) begin
            op = 8'($urandom);
            if (t % 7 == 3) for (int s = 0; s < 8; s++) rom[{op, 3'(s)}][15] = 1'b0;
            for (int s = 0; s < 8; s++) stall_n[s] = int'($urandom_range(0, 2));
            nr = ($urandom_range(0, 3) != 0);
            run_instr(op, nr);
            if (!nr) begin
                run = 1'b1;
                next_cycle();
            end
        end

        // Reset in the middle of a stall with the error flag set
        op = 8'h55;
        rom[{op, 3'd0}] = 24'hFF9FFE & ~24'h004000;
        chk("pre_err", 32'(ucode_err), 32'(err_exp));
        chk("pre_fetch", 32'(fetch), 32'd1);
        prog = op;
        next_cycle();
        mem_rdy = 1'b0;
        #1;
        chk("mid_stall_ua", 32'(ua), 32'({op, 3'd0}));
        rst = 1'b1;
        next_cycle();
        chk("rst_stall_busy", 32'(busy), 32'd0);
        chk("rst_stall_ir", 32'(ir), 32'd0);
        chk("rst_stall_step", 32'(step), 32'd0);
        chk("rst_stall_err", 32'(ucode_err), 32'd0);
        chk("rst_stall_ctl", 32'(ctl), 32'(NOP));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
